mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access unit that consumes the EX/MEM pipeline register outputs, performs the load/store on the data-memory bus through a valid/ready handshake, and registers the MEM/WB pipeline values. It stalls the upstream pipeline while a bus access is outstanding. It also handles byte/half/word lane steering, load sign extension, misalignment detection, and a bus timeout.

## Interface
- `TIMEOUT`, 16: maximum number of wait cycles before an access is aborted (must be ≥1).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted at 0).
- `ALUResultM` input 32: effective address, or the ALU result for non-memory instructions.
- `WriteDataM` input 32: store data.
- `RdM` input 5: destination register.
- `PCPlus4M` input 32: PC+4.
- `RegWriteM`, `MemReadM`, `MemWriteM` input 1 each: control bits from EX/MEM.
- `ResultSrcM` input 2: writeback source select, passed through.
- `Funct3M` input 3: access size and sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- `dmem_req` output 1: bus request valid.
- `dmem_we` output 1: 1 = write.
- `dmem_addr` output 32: word-aligned address (low 2 bits are 0).
- `dmem_wdata` output 32: lane-steered store data.
- `dmem_be` output 4: byte enables.
- `dmem_ready` input 1: the responder accepts or completes the access this cycle.
- `dmem_rdata` input 32: read word; valid when `dmem_ready`=1 and `dmem_we`=0.
- `StallM` output 1: hold the IF/ID/EX stages and the EX/MEM register.
- `ALUResultW`, `ReadDataW`, `PCPlus4W` output 32 each: MEM/WB values.
- `RdW` output 5, `ResultSrcW` output 2, `RegWriteW` output 1: MEM/WB values.
- `MisalignW`, `BusErrW` output 1 each: one-cycle exception flags, aligned with the WB values.

## Operation
- FSM states: IDLE and BUSY.
- In IDLE, a memory operation (`MemReadM` or `MemWriteM`) that is aligned drives `dmem_req`=1 combinationally.
  - If `dmem_ready`=1 in the same cycle: zero-wait completion, and the unit stays in IDLE.
  - Otherwise: latch the address, write data, byte enables, `Funct3M`, and all control and passthrough fields. Go to BUSY and clear the wait counter.
- In BUSY:
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_be` are driven from the latched values. They must not change until the access completes.
  - The counter increments each cycle.
  - `dmem_ready`=1: complete the access and go to IDLE.
  - Counter reaches `TIMEOUT` with no ready: abort, pulse `BusErrW`=1, force `RegWriteW`=0, and go to IDLE.
- Rule: `StallM` = (IDLE and aligned memory op and not `dmem_ready`) or (BUSY and not completing or aborting this cycle).
- Alignment:
  - Halfword: misaligned if `addr[0]`=1.
  - Word: misaligned if `addr[1:0]`≠0.
  - A misaligned access issues no request and causes no stall. WB gets `MisalignW`=1 and `RegWriteW`=0.
- Stores:
  - `dmem_be`: SB = 0001<<`addr[1:0]`; SH = 0011<<`addr[1:0]`; SW = 1111.
  - `dmem_wdata` replicates the byte or half across all lanes.
- Loads:
  - Select the byte or half using the latched `addr[1:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Undefined `Funct3M` encodings are treated as LW/SW.
- Non-memory instructions: pass straight through to the WB registers with no stall. `ReadDataW` = 0.

## Timing
- MEM/WB registers update on every rising edge where `StallM`=0.
- When `StallM`=1, `RegWriteW`, `MisalignW` and `BusErrW` are loaded with 0 (a bubble). The other WB fields hold.
- Latency:
  - Zero-wait access: 1 cycle, from EX/MEM valid to WB valid on the next edge.
  - An access with N wait cycles stalls for N cycles.
  - Timeout: `StallM` is high for `TIMEOUT` cycles, then WB gets the error bubble.
- `dmem_ready` while `dmem_req`=0 is ignored.
- Reset (asynchronous):
  - State = IDLE and counter = 0.
  - All W outputs are 0, including `RegWriteW`, `MisalignW` and `BusErrW`.
  - The bus outputs go to 0 immediately. A reset asserted mid-BUSY drops `dmem_req` asynchronously.
- The inputs are assumed stable while `StallM`=1, because the upstream register holds. The unit nevertheless uses its latched copies while in BUSY.

## Test plan
- LW at 0x100, `dmem_ready` tied to 1, rdata 0xDEADBEEF -> `dmem_be`=1111, `StallM` never asserted, next cycle `ReadDataW`=0xDEADBEEF with `RegWriteW`=1.
- LB at 0x103, rdata 0x80112233, ready after 3 wait cycles -> `StallM` high for 3 cycles, request fields constant throughout, `ReadDataW`=0xFFFFFF80. The same access as LBU -> 0x00000080.
- SH at 0x202, data 0x0000ABCD, ready immediately -> `dmem_addr`=0x200, `dmem_be`=1100, `dmem_wdata`=0xABCDABCD, `dmem_we`=1.
- LW at 0x101 -> no `dmem_req`, no stall, next cycle `MisalignW`=1 and `RegWriteW`=0.
- Load with ready never asserted and `TIMEOUT`=16 -> `StallM` high for 16 cycles, then `BusErrW` pulses for 1 cycle, `RegWriteW`=0, FSM back in IDLE.
- Reset driven low during BUSY after 2 wait cycles -> `dmem_req`=0 and all W outputs 0 immediately. After release, a new SW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives the data-memory valid/ready bus from EX/MEM,
// stalls the pipeline while an access is outstanding, and registers MEM/WB values.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic [1:0]  ResultSrcW,
  output logic        RegWriteW,
  output logic        MisalignW,
  output logic        BusErrW
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic          complete, abort, latch_en;

  logic [31:0] lat_addr, lat_wdata, lat_pc;
  logic [3:0]  lat_be;
  logic [2:0]  lat_f3;
  logic [4:0]  lat_rd;
  logic [1:0]  lat_rs;
  logic        lat_we, lat_rw;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Byte/half extraction from the read word, then sign or zero extension.
  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = 16'(d >> {a[1], 4'b0000});
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

  logic        mem_op, mis_c, mis_op, busy;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_c;
  logic [31:0] src_alu, src_pc;
  logic [4:0]  src_rd;
  logic [1:0]  src_rs;
  logic [2:0]  src_f3;
  logic        src_rw, src_we;

  assign mem_op  = MemReadM | MemWriteM;
  assign mis_c   = is_misaligned(Funct3M, ALUResultM[1:0]);
  assign be_c    = lane_be(Funct3M, ALUResultM[1:0]);
  assign wdata_c = store_data(Funct3M, WriteDataM);
  assign busy    = (state == BUSY);
  assign mis_op  = !busy && mem_op && mis_c;

  // WB source: live EX/MEM fields in IDLE, latched copies while an access is outstanding.
  assign src_alu = busy ? lat_addr : ALUResultM;
  assign src_pc  = busy ? lat_pc   : PCPlus4M;
  assign src_rd  = busy ? lat_rd   : RdM;
  assign src_rs  = busy ? lat_rs   : ResultSrcM;
  assign src_f3  = busy ? lat_f3   : Funct3M;
  assign src_rw  = busy ? lat_rw   : RegWriteM;
  assign src_we  = busy ? lat_we   : MemWriteM;
  assign load_c  = load_data(src_f3, src_alu[1:0], dmem_rdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    StallM     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    latch_en   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !mis_c) begin
          dmem_req   = 1'b1;
          dmem_we    = MemWriteM;
          dmem_addr  = {ALUResultM[31:2], 2'b00};
          dmem_wdata = wdata_c;
          dmem_be    = be_c;
          if (dmem_ready) begin
            complete = 1'b1;
          end else begin
            StallM     = 1'b1;
            latch_en   = 1'b1;
            next_state = BUSY;
            cnt_next   = '0;
          end
        end
      end
      BUSY: begin
        dmem_req   = 1'b1;
        dmem_we    = lat_we;
        dmem_addr  = {lat_addr[31:2], 2'b00};
        dmem_wdata = lat_wdata;
        dmem_be    = lat_be;
        if (dmem_ready) begin
          complete   = 1'b1;
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt == LAST) begin
          abort      = 1'b1;
          next_state = IDLE;
          cnt_next   = '0;
        end else begin
          StallM   = 1'b1;
          cnt_next = cnt + CW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
    // Reset drops the bus immediately, even mid-access.
    if (!reset) begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_be    = '0;
      StallM     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_pc    <= '0;
      lat_be    <= '0;
      lat_f3    <= '0;
      lat_rd    <= '0;
      lat_rs    <= '0;
      lat_we    <= 1'b0;
      lat_rw    <= 1'b0;
    end else if (latch_en) begin
      lat_addr  <= ALUResultM;
      lat_wdata <= wdata_c;
      lat_pc    <= PCPlus4M;
      lat_be    <= be_c;
      lat_f3    <= Funct3M;
      lat_rd    <= RdM;
      lat_rs    <= ResultSrcM;
      lat_we    <= MemWriteM;
      lat_rw    <= RegWriteM;
    end
  end

  // MEM/WB register; a stall inserts a bubble by clearing only the valid-like flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      ResultSrcW <= '0;
      RegWriteW  <= 1'b0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
      BusErrW   <= 1'b0;
    end else begin
      ALUResultW <= src_alu;
      ReadDataW  <= (complete && !src_we) ? load_c : 32'd0;
      PCPlus4W   <= src_pc;
      RdW        <= src_rd;
      ResultSrcW <= src_rs;
      RegWriteW  <= src_rw && !abort && !mis_op;
      MisalignW  <= mis_op;
      BusErrW    <= abort;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-cycle vector table plus
// hand-written wait-state, timeout and mid-access reset sequences.
module tb_mem_access_unit;

  localparam int unsigned TO = 16;
  localparam int NV = 14;

  logic        clk, reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemReadM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW;
  logic        RegWriteW, MisalignW, BusErrW;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .StallM(StallM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] alu, wd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [2:0]  f3;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_read;
    logic        e_rw, e_mis;
  } vec_t;

  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [31:0] alu, wd, input logic [4:0] rd,
                              input logic rw, mr, mw, input logic [2:0] f3,
                              input logic rdy, input logic [31:0] rdata,
                              input logic e_req, e_we, input logic [31:0] e_addr, e_wdata,
                              input logic [3:0] e_be, input logic [31:0] e_read,
                              input logic e_rw, e_mis);
    vec_t v;
    v.alu = alu; v.wd = wd; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw; v.f3 = f3;
    v.rdy = rdy; v.rdata = rdata; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_be = e_be; v.e_read = e_read; v.e_rw = e_rw; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, wd, input logic [4:0] rd,
                       input logic rw, mr, mw, input logic [2:0] f3,
                       input logic rdy, input logic [31:0] rdata);
    ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = alu + 32'd4;
    RegWriteM = rw; MemReadM = mr; MemWriteM = mw; ResultSrcM = rd[1:0];
    Funct3M = f3; dmem_ready = rdy; dmem_rdata = rdata;
  endtask

  task automatic nop();
    drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'd0);
  endtask

  task automatic check_w(input string tag, input logic [31:0] alu, pc, read,
                         input logic [4:0] rd, input logic rw, mis, berr);
    check({tag, " ALUResultW"}, ALUResultW, alu);
    check({tag, " PCPlus4W"}, PCPlus4W, pc);
    check({tag, " ReadDataW"}, ReadDataW, read);
    check({tag, " RdW"}, 32'(RdW), 32'(rd));
    check({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'(rd[1:0]));
    check({tag, " RegWriteW"}, 32'(RegWriteW), 32'(rw));
    check({tag, " MisalignW"}, 32'(MisalignW), 32'(mis));
    check({tag, " BusErrW"}, 32'(BusErrW), 32'(berr));
  endtask

  task automatic check_bus(input string tag, input logic req, we,
                           input logic [31:0] addr, wdata, input logic [3:0] be,
                           input logic stall);
    check({tag, " dmem_req"}, 32'(dmem_req), 32'(req));
    check({tag, " dmem_we"}, 32'(dmem_we), 32'(we));
    check({tag, " dmem_addr"}, dmem_addr, addr);
    check({tag, " dmem_wdata"}, dmem_wdata, wdata);
    check({tag, " dmem_be"}, 32'(dmem_be), 32'(be));
    check({tag, " StallM"}, 32'(StallM), 32'(stall));
  endtask

  // Byte load at 0x103 with three wait cycles, then ready.
  task automatic wait_load(input string tag, input logic [2:0] f3, input logic [31:0] exp);
    drive(32'h103, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, f3, 1'b0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_bus($sformatf("%s wait%0d", tag, c), 1'b1, 1'b0, 32'h100, 32'd0, 4'b1000, 1'b1);
      @(posedge clk); #1;
      check({tag, " bubble RegWriteW"}, 32'(RegWriteW), 32'd0);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80112233;
    @(negedge clk);
    check_bus({tag, " done"}, 1'b1, 1'b0, 32'h100, 32'd0, 4'b1000, 1'b0);
    @(posedge clk); #1;
    check_w(tag, 32'h103, 32'h107, exp, 5'd12, 1'b1, 1'b0, 1'b0);
    nop();
  endtask

  initial begin
    int n;
    vecs[0]  = mk(32'h100, 32'h0, 5'd5, 1, 1, 0, 3'b010, 1, 32'hDEADBEEF,
                  1, 0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1, 0);
    vecs[1]  = mk(32'h202, 32'h0000ABCD, 5'd0, 0, 0, 1, 3'b001, 1, 32'h0,
                  1, 1, 32'h200, 32'hABCDABCD, 4'hC, 32'h0, 0, 0);
    vecs[2]  = mk(32'h101, 32'h0, 5'd6, 1, 1, 0, 3'b010, 0, 32'h0,
                  0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 1);
    vecs[3]  = mk(32'h12345678, 32'hFFFF0000, 5'd7, 1, 0, 0, 3'b000, 1, 32'h55555555,
                  0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 0);
    vecs[4]  = mk(32'h102, 32'h0, 5'd8, 1, 1, 0, 3'b001, 1, 32'h80015555,
                  1, 0, 32'h100, 32'h0, 4'hC, 32'hFFFF8001, 1, 0);
    vecs[5]  = mk(32'h102, 32'h0, 5'd9, 1, 1, 0, 3'b101, 1, 32'h80015555,
                  1, 0, 32'h100, 32'h0, 4'hC, 32'h00008001, 1, 0);
    vecs[6]  = mk(32'h101, 32'h000000A5, 5'd0, 0, 0, 1, 3'b000, 1, 32'h0,
                  1, 1, 32'h100, 32'hA5A5A5A5, 4'h2, 32'h0, 0, 0);
    vecs[7]  = mk(32'h203, 32'h0, 5'd9, 1, 1, 0, 3'b001, 1, 32'h1234,
                  0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 1);
    vecs[8]  = mk(32'h101, 32'h0, 5'd10, 1, 1, 0, 3'b100, 1, 32'h11228344,
                  1, 0, 32'h100, 32'h0, 4'h2, 32'h00000083, 1, 0);
    vecs[9]  = mk(32'h100, 32'h0, 5'd11, 1, 1, 0, 3'b000, 1, 32'h1122837F,
                  1, 0, 32'h100, 32'h0, 4'h1, 32'h0000007F, 1, 0);
    vecs[10] = mk(32'h10C, 32'h0, 5'd13, 1, 1, 0, 3'b011, 1, 32'hCAFEF00D,
                  1, 0, 32'h10C, 32'h0, 4'hF, 32'hCAFEF00D, 1, 0);
    vecs[11] = mk(32'h20C, 32'h01020304, 5'd0, 0, 0, 1, 3'b010, 1, 32'h0,
                  1, 1, 32'h20C, 32'h01020304, 4'hF, 32'h0, 0, 0);
    vecs[12] = mk(32'h003, 32'h12345678, 5'd0, 0, 0, 1, 3'b000, 1, 32'h0,
                  1, 1, 32'h0, 32'h78787878, 4'h8, 32'h0, 0, 0);
    vecs[13] = mk(32'h201, 32'h0000BEEF, 5'd0, 0, 0, 1, 3'b001, 1, 32'h0,
                  0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 1);

    // Reset state: bus gated off even with a pending aligned load on the inputs.
    reset = 1'b0;
    drive(32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0);
    #3;
    check_bus("reset", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check_w("reset", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    nop();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].alu, vecs[i].wd, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].mw,
            vecs[i].f3, vecs[i].rdy, vecs[i].rdata);
      @(negedge clk);
      check_bus($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_we, vecs[i].e_addr,
                vecs[i].e_wdata, vecs[i].e_be, 1'b0);
      @(posedge clk); #1;
      check_w($sformatf("v%0d", i), vecs[i].alu, vecs[i].alu + 32'd4, vecs[i].e_read,
              vecs[i].rd, vecs[i].e_rw, vecs[i].e_mis, 1'b0);
    end

    // Hold check: the first stalled cycle keeps the previous WB address.
    drive(32'h103, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("hold ALUResultW", ALUResultW, 32'h201);
    check("hold MisalignW", 32'(MisalignW), 32'd0);
    nop();
    @(posedge clk); #1;
    @(posedge clk); #1;

    wait_load("lb_wait", 3'b000, 32'hFFFFFF80);
    wait_load("lbu_wait", 3'b100, 32'h00000080);

    // Timeout: ready never arrives.
    drive(32'h300, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!StallM) break;
      n++;
      if (dmem_addr !== 32'h300 || dmem_req !== 1'b1) check("timeout req held", dmem_addr, 32'h300);
      @(posedge clk);
    end
    check("timeout stall cycles", 32'(n), 32'(TO));
    @(posedge clk); #1;
    check_w("timeout", 32'h300, 32'h304, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1);
    nop();
    @(posedge clk); #1;
    check("timeout pulse end BusErrW", 32'(BusErrW), 32'd0);

    drive(32'h500, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 32'h0BADF00D);
    @(negedge clk);
    check_bus("post_timeout", 1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    check_w("post_timeout", 32'h500, 32'h504, 32'h0BADF00D, 5'd10, 1'b1, 1'b0, 1'b0);

    // Reset asserted while an access is outstanding.
    drive(32'h400, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy StallM", 32'(StallM), 32'd1);
    check("busy dmem_addr", dmem_addr, 32'h400);
    #2 reset = 1'b0;
    #1;
    check_bus("mid_reset", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check_w("mid_reset", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    drive(32'h404, 32'h11223344, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_bus("sw_after_reset", 1'b1, 1'b1, 32'h404, 32'h11223344, 4'hF, 1'b0);
    @(posedge clk); #1;
    check_w("sw_after_reset", 32'h404, 32'h408, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    nop();
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
